// File: rtl/fp_dot_pkg.sv
// Shared types and constants for the FP16 dot-product sequencer.
package fp_dot_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    AB,
    ADD,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/fp_dot_seq_if.sv
// Operand/result link between the dot-product sequencer (master) and the FP16 MAC (slave).
interface fp_dot_seq_if;
  import fp_dot_pkg::*;

  logic              mac_val;
  logic              mac_enA;
  logic              mac_enB;
  logic [FP16_W-1:0] mac_opA;
  logic [FP16_W-1:0] mac_opB;
  logic              mac_enADD;
  logic [FP16_W-1:0] mac_opADD;
  logic              mac_val_i;
  logic [FP16_W-1:0] mac_out_i;

  modport master (
    output mac_val, mac_enA, mac_enB, mac_opA, mac_opB, mac_enADD, mac_opADD,
    input  mac_val_i, mac_out_i
  );

  modport slave (
    input  mac_val, mac_enA, mac_enB, mac_opA, mac_opB, mac_enADD, mac_opADD,
    output mac_val_i, mac_out_i
  );

endinterface

// File: rtl/fp_dot_buf.sv
// Paired A/B operand register arrays: one host write port, one shared read index.
module fp_dot_buf
  import fp_dot_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FP16_W-1:0] wdata_a,
  input  logic [FP16_W-1:0] wdata_b,
  input  logic [AW-1:0]     raddr,
  output logic [FP16_W-1:0] rdata_a,
  output logic [FP16_W-1:0] rdata_b
);

  logic [FP16_W-1:0] vec_a_q [DEPTH];
  logic [FP16_W-1:0] vec_b_q [DEPTH];

  // Contents are loaded by the host before use, so the arrays carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      vec_a_q[waddr] <= wdata_a;
      vec_b_q[waddr] <= wdata_b;
    end
  end

  assign rdata_a = vec_a_q[raddr];
  assign rdata_b = vec_b_q[raddr];

endmodule

// File: rtl/fp_dot_seq.sv
// Streams buffered FP16 operand pairs into the MAC, feeding the running sum back
// as the addend, and reports the dot product with a one-cycle done pulse.
module fp_dot_seq
  import fp_dot_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FP16_W-1:0] wr_a,
  input  logic [FP16_W-1:0] wr_b,
  input  logic              start,
  input  logic [AW:0]       len,
  output logic              busy,
  output logic              done,
  output logic [FP16_W-1:0] result,
  output logic              err,
  fp_dot_seq_if.master      mac
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [AW:0]       idx_q, idx_d, idx_inc;
  logic [AW:0]       len_q, len_d;
  logic [FP16_W-1:0] acc_q, acc_d;
  logic [FP16_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic              buf_we;
  logic [FP16_W-1:0] rd_a, rd_b;

  fp_dot_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk    (clk),
    .we     (buf_we),
    .waddr  (wr_addr),
    .wdata_a(wr_a),
    .wdata_b(wr_b),
    .raddr  (idx_q[AW-1:0]),
    .rdata_a(rd_a),
    .rdata_b(rd_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      acc_q    <= FP16_ZERO;
      result_q <= FP16_ZERO;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // MAC results arrive two cycles after issue, so element i's sum is picked up
  // in the AB slot of element i+1, and the final one in DRAIN.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    acc_d         = acc_q;
    result_d      = result_q;
    err_d         = err_q;
    buf_we        = 1'b0;
    idx_inc       = idx_q + 1'b1;
    mac.mac_val   = 1'b0;
    mac.mac_enA   = 1'b0;
    mac.mac_enB   = 1'b0;
    mac.mac_opA   = FP16_ZERO;
    mac.mac_opB   = FP16_ZERO;
    mac.mac_enADD = 1'b0;
    mac.mac_opADD = FP16_ZERO;

    case (state_q)
      IDLE: begin
        buf_we = wr_en;
        if (start) begin
          err_d = 1'b0;
          if (len == '0) begin
            result_d = FP16_ZERO;
            state_d  = DONE;
          end else begin
            len_d   = (len > LEN_MAX) ? LEN_MAX : len;
            idx_d   = '0;
            state_d = AB;
          end
        end
      end
      AB: begin
        mac.mac_val = 1'b1;
        mac.mac_enA = 1'b1;
        mac.mac_enB = 1'b1;
        mac.mac_opA = rd_a;
        mac.mac_opB = rd_b;
        if (idx_q != '0) begin
          acc_d = mac.mac_out_i;
          if (!mac.mac_val_i) err_d = 1'b1;
        end
        state_d = ADD;
      end
      ADD: begin
        mac.mac_val   = 1'b1;
        mac.mac_enADD = 1'b1;
        mac.mac_opADD = (idx_q == '0) ? FP16_ZERO : acc_q;
        idx_d         = idx_inc;
        state_d       = (idx_inc < len_q) ? AB : DRAIN;
      end
      DRAIN: begin
        acc_d    = mac.mac_out_i;
        result_d = mac.mac_out_i;
        if (!mac.mac_val_i) err_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == AB) || (state_q == ADD) || (state_q == DRAIN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fp_dot_seq.sv
// Bench for fp_dot_seq: a behavioural FP16 MAC on the slave side, a dot-product
// model derived from the loaded vectors, and a per-cycle compare process.
module tb_fp_dot_seq;
  import fp_dot_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_a    = '0;
  logic [15:0]   wr_b    = '0;
  logic          start   = 1'b0;
  logic [AW:0]   len     = '0;
  logic          busy, done, err;
  logic [15:0]   result;

  fp_dot_seq_if mac_if ();

  fp_dot_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_a   (wr_a),
    .wr_b   (wr_b),
    .start  (start),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .mac    (mac_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // FP16 <-> real conversions (normal numbers and zero are all this bench needs).
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v;
    if (e == 0) v = real'(m) * pow2(-24);
    else v = (1.0 + real'(m) / 1024.0) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    real  a;
    int   e;
    int   f;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    f = int'((a - 1.0) * 1024.0);
    if (f == 1024) begin f = 0; e++; end
    return {s, e[4:0], f[9:0]};
  endfunction

  // Behavioural MAC: product at issue+1, sum with the addend visible at issue+2.
  bit          mac_dead = 1'b0;
  real         mac_prod = 0.0;
  bit          mac_v1   = 1'b0;
  bit          mac_v2   = 1'b0;
  logic [15:0] mac_sum  = 16'h0000;

  always @(posedge clk) begin
    mac_v1   <= mac_if.mac_val && mac_if.mac_enA && mac_if.mac_enB;
    mac_prod <= fp16_to_real(mac_if.mac_opA) * fp16_to_real(mac_if.mac_opB);
    mac_v2   <= mac_v1 && mac_if.mac_val && mac_if.mac_enADD;
    mac_sum  <= real_to_fp16(mac_prod + fp16_to_real(mac_if.mac_opADD));
  end

  assign mac_if.mac_val_i = mac_dead ? 1'b0 : mac_v2;
  assign mac_if.mac_out_i = mac_dead ? 16'h0000 : mac_sum;

  // Model state: shadow of the buffers and the expected run in flight.
  logic [15:0] sh_a [DEPTH];
  logic [15:0] sh_b [DEPTH];
  logic [15:0] part [DEPTH];
  bit          run_on      = 1'b0;
  int          run_s       = 0;
  int          run_n       = 0;
  logic [15:0] exp_result  = 16'h0000;
  bit          exp_err     = 1'b0;
  logic [15:0] last_result = 16'h0000;
  bit          last_err    = 1'b0;
  int          done_cnt    = 0;
  int          done_lat    = -1;
  logic [15:0] done_res    = 16'h0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  always @(negedge clk) begin : compare
    int rel, j, last_rel;
    if (done === 1'b1) begin
      done_cnt++;
      done_lat = cyc - run_s;
      done_res = result;
    end
    if (!reset_n) begin
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_err", 32'(err), 0);
      checkOutput("rst_result", 32'(result), 0);
      checkOutput("rst_mac_ctl", 32'({mac_if.mac_val, mac_if.mac_enA, mac_if.mac_enB, mac_if.mac_enADD}), 0);
      checkOutput("rst_mac_ops", 32'(mac_if.mac_opA | mac_if.mac_opB | mac_if.mac_opADD), 0);
    end else if (run_on) begin
      rel      = cyc - run_s;
      last_rel = (run_n == 0) ? 1 : 2 * run_n + 2;
      checkOutput("busy", 32'(busy), 32'(run_n > 0 && rel >= 1 && rel < last_rel));
      checkOutput("done", 32'(done), 32'(rel == last_rel));
      checkOutput("mac_val", 32'(mac_if.mac_val), 32'(rel >= 1 && rel < last_rel - 1));
      if (rel >= 1 && rel < last_rel - 1) begin
        j = (rel - 1) / 2;
        if (rel % 2 == 1) begin
          checkOutput("issue_ab", 32'({mac_if.mac_enA, mac_if.mac_enB, mac_if.mac_enADD}), 32'b110);
          checkOutput("opA", 32'(mac_if.mac_opA), 32'(sh_a[j]));
          checkOutput("opB", 32'(mac_if.mac_opB), 32'(sh_b[j]));
        end else begin
          checkOutput("issue_add", 32'({mac_if.mac_enA, mac_if.mac_enB, mac_if.mac_enADD}), 32'b001);
          if (j == 0) checkOutput("opADD_first", 32'(mac_if.mac_opADD), 0);
          else checkOutput("opADD", 32'(mac_if.mac_opADD), 32'(part[j-1]));
        end
      end
      if (rel == 1 && run_n > 0) checkOutput("err_cleared_on_start", 32'(err), 0);
      if (rel == last_rel) begin
        checkOutput("result", 32'(result), 32'(exp_result));
        checkOutput("err", 32'(err), 32'(exp_err));
        last_result = exp_result;
        last_err    = exp_err;
        run_on      = 1'b0;
      end else begin
        checkOutput("result_hold", 32'(result), 32'(last_result));
      end
    end else begin
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_done", 32'(done), 0);
      checkOutput("idle_mac_val", 32'(mac_if.mac_val), 0);
      checkOutput("idle_result", 32'(result), 32'(last_result));
      checkOutput("idle_err", 32'(err), 32'(last_err));
    end
  end

  task automatic loadEntry(input int addr, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_a    = a;
    wr_b    = b;
    sh_a[addr] = a;
    sh_b[addr] = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issues start and derives the expected partial sums from the shadow vectors.
  task automatic applyStimulus(input int n_req);
    logic [15:0] acc;
    @(posedge clk); #1;
    start = 1'b1;
    len   = (AW+1)'(n_req);
    run_n = (n_req > DEPTH) ? DEPTH : n_req;
    acc   = 16'h0000;
    for (int k = 0; k < run_n; k++) begin
      if (!mac_dead) acc = real_to_fp16(fp16_to_real(sh_a[k]) * fp16_to_real(sh_b[k]) + fp16_to_real(acc));
      part[k] = acc;
    end
    exp_result = acc;
    exp_err    = mac_dead && (run_n > 0);
    run_s      = cyc;
    run_on     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitRun(input int budget);
    for (int i = 0; i < budget && run_on; i++) @(posedge clk);
    if (run_on) begin
      chk_cnt++;
      $display("[TB] FAIL run_timeout: done not seen within %0d cycles, expected by cycle %0d", budget, run_s + 2 * run_n + 2);
      run_on = 1'b0;
    end
    #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    logic [15:0] vec_a [3];
    logic [15:0] vec_b [3];
    vec_a = '{16'h3C00, 16'h4000, 16'h4200};
    vec_b = '{16'h4000, 16'h4000, 16'h4000};

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    checkOutput("reset_result", 32'(result), 0);
    checkOutput("reset_err", 32'(err), 0);

    for (int k = 0; k < DEPTH; k++) begin
      if (k < 3) loadEntry(k, vec_a[k], vec_b[k]);
      else loadEntry(k, 16'h0000, 16'h0000);
    end

    $display("[TB] three-element dot product");
    d0 = done_cnt;
    applyStimulus(3);
    waitRun(40);
    checkOutput("dot3_result", 32'(done_res), 32'h4A00);
    checkOutput("dot3_latency", 32'(done_lat), 8);
    checkOutput("dot3_done_count", 32'(done_cnt - d0), 1);

    $display("[TB] single element");
    loadEntry(0, 16'h4200, 16'h3800);
    applyStimulus(1);
    waitRun(20);
    checkOutput("dot1_result", 32'(done_res), 32'h3E00);
    checkOutput("dot1_latency", 32'(done_lat), 4);

    $display("[TB] zero length");
    applyStimulus(0);
    waitRun(10);
    checkOutput("len0_result", 32'(done_res), 0);
    checkOutput("len0_latency", 32'(done_lat), 1);

    $display("[TB] silent MAC sets err, next start clears it");
    mac_dead = 1'b1;
    applyStimulus(2);
    waitRun(20);
    checkOutput("dead_err", 32'(err), 1);
    mac_dead = 1'b0;
    applyStimulus(2);
    waitRun(20);
    checkOutput("live_err", 32'(err), 0);
    checkOutput("dot2_result", 32'(done_res), 32'h4580);

    $display("[TB] reset during second accumulate");
    loadEntry(0, 16'h3C00, 16'h4000);
    applyStimulus(3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_in_add", 32'(mac_if.mac_enADD), 1);
    reset_n     = 1'b0;
    run_on      = 1'b0;
    last_result = 16'h0000;
    last_err    = 1'b0;
    d0          = done_cnt;
    #1;
    checkOutput("reset_now_busy", 32'(busy), 0);
    checkOutput("reset_now_mac_val", 32'(mac_if.mac_val), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    checkOutput("reset_no_done", 32'(done_cnt - d0), 0);
    applyStimulus(3);
    waitRun(40);
    checkOutput("after_reset_result", 32'(done_res), 32'h4A00);

    $display("[TB] start and write pulses mid-run");
    d0 = done_cnt;
    applyStimulus(3);
    repeat (2) @(posedge clk);
    #1;
    start   = 1'b1;
    len     = '0;
    wr_en   = 1'b1;
    wr_addr = AW'(1);
    wr_a    = 16'h5000;
    wr_b    = 16'h5000;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    waitRun(40);
    checkOutput("midrun_result", 32'(done_res), 32'h4A00);
    checkOutput("midrun_done_count", 32'(done_cnt - d0), 1);
    applyStimulus(3);
    waitRun(40);
    checkOutput("buffer_unchanged_result", 32'(done_res), 32'h4A00);

    $display("[TB] over-length request clamps to depth");
    applyStimulus(20);
    waitRun(60);
    checkOutput("clamp_latency", 32'(done_lat), 34);
    checkOutput("clamp_result", 32'(done_res), 32'h4A00);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
